score_tally: RTL

//  Downstream of the per-beat hit judge. Captures the judge's 2-bit point value at each beat

---
 rtl/score_pkg.sv | 15 +
 rtl/score_tally_bcd_add_sat.sv | 44 ++++
 rtl/score_tally.sv | 126 ++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score tally block: FSM encoding and BCD score limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

endpackage

// File: rtl/score_tally_bcd_add_sat.sv
// Adds a small binary addend (0..7) to a 4-digit packed BCD value, saturating at 9999.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a    in  16  current score, {thousands,hundreds,tens,ones} BCD
//   b    in  3   binary addend, applied to the ones digit
//   sum  out 16  a + b in BCD; 16'h9999 if the result would exceed 9999
module bcd_add_sat
    import score_pkg::*;
(
    input  logic [15:0] a,
    input  logic [2:0]  b,
    output logic [15:0] sum
);

    logic [4:0]  carry;
    logic [4:0]  digit;
    logic [4:0]  adj;
    logic [15:0] sum_raw;

    // Ripple the addend through the digits. The ones digit sees the full
    // addend (at most 9+7=16); every later digit sees at most a carry of 1.
    always_comb begin
        carry   = {2'b00, b};
        digit   = '0;
        adj     = '0;
        sum_raw = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            digit = {1'b0, a[4*i +: 4]} + carry;
            adj   = digit - 5'd10;
            if (digit > 5'd9) begin
                sum_raw[4*i +: 4] = adj[3:0];
                carry             = 5'd1;
            end else begin
                sum_raw[4*i +: 4] = digit[3:0];
                carry             = 5'd0;
            end
        end
        // A carry out of the thousands digit means the score passed 9999.
        sum = (carry != 5'd0) ? BCD_MAX : sum_raw;
    end

endmodule

// File: rtl/score_tally.sv
// Tallies per-beat judge results into a saturating BCD score, combo, max combo and beat count.
// Latency: 1 clk from the first clk sampling tick_out high to updated outputs and score_upd.
// Backpressure: none; one commit per tick_out rising edge while playing, edges otherwise dropped.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        one-cycle pulse: clear tallies and enter PLAY (wins over a same-cycle beat)
//   tick_out     beat boundary level from the beat generator
//   point        judge result for the current beat (0 = miss), cleared by the judge while tick_out is high
//   score_bcd    saturating 4-digit BCD score
//   combo        current consecutive-hit count (saturating)
//   max_combo    best combo since start
//   beat_cnt     committed beats since start
//   score_upd    one-cycle pulse per committed beat
//   game_over    high once NUM_BEATS beats have been committed
// Build option: define SCORE_COMBO_BONUS_EN to double hit points once the combo
// (before this beat) has reached COMBO_THRESH.
module score_tally
    import score_pkg::*;
#(
    parameter int NUM_BEATS    = 64,
    parameter int COMBO_THRESH = 8,
    parameter int COMBO_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick_out,
    input  logic [1:0]         point,
    output logic [15:0]        score_bcd,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [7:0]         beat_cnt,
    output logic               score_upd,
    output logic               game_over
);

`ifdef SCORE_COMBO_BONUS_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    localparam logic [COMBO_W-1:0] COMBO_MAX   = {COMBO_W{1'b1}};
    localparam logic [COMBO_W-1:0] COMBO_LIMIT = COMBO_W'(COMBO_THRESH);
    localparam logic [7:0]         LAST_BEAT   = 8'(NUM_BEATS);

    state_t             state;
    logic               tick_d;
    logic [1:0]         pt_hold;
    logic               tick_edge;
    logic               commit;
    logic               hit;
    logic               bonus;
    logic [2:0]         add_val;
    logic [15:0]        score_sum;
    logic [COMBO_W-1:0] combo_nxt;
    logic [7:0]         beat_nxt;

    // The judge zeroes point while tick_out is high, so the value used for a
    // beat is the one captured during the preceding low phase.
    assign tick_edge = tick_out & ~tick_d;
    assign commit    = tick_edge && (state == PLAY);
    assign hit       = (pt_hold != 2'd0);

    // Bonus looks at the combo before this beat's increment.
    assign bonus   = BONUS_EN && hit && (combo >= COMBO_LIMIT);
    assign add_val = bonus ? {pt_hold, 1'b0} : {1'b0, pt_hold};

    always_comb begin
        combo_nxt = '0;
        if (hit) begin
            combo_nxt = (combo == COMBO_MAX) ? combo : combo + 1'b1;
        end
    end

    assign beat_nxt = beat_cnt + 8'd1;

    bcd_add_sat u_bcd_add_sat (
        .a   (score_bcd),
        .b   (add_val),
        .sum (score_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_d    <= 1'b0;
            pt_hold   <= 2'd0;
            score_bcd <= '0;
            combo     <= '0;
            max_combo <= '0;
            beat_cnt  <= '0;
            score_upd <= 1'b0;
            game_over <= 1'b0;
        end else begin
            tick_d    <= tick_out;
            score_upd <= 1'b0;
            if (!tick_out) begin
                pt_hold <= point;
            end

            if (start) begin
                // start takes priority over any beat edge in the same cycle.
                state     <= PLAY;
                pt_hold   <= 2'd0;
                score_bcd <= '0;
                combo     <= '0;
                max_combo <= '0;
                beat_cnt  <= '0;
                game_over <= 1'b0;
            end else if (commit) begin
                score_bcd <= score_sum;
                combo     <= combo_nxt;
                max_combo <= (combo_nxt > max_combo) ? combo_nxt : max_combo;
                beat_cnt  <= beat_nxt;
                score_upd <= 1'b1;
                if (beat_nxt == LAST_BEAT) begin
                    state     <= DONE;
                    game_over <= 1'b1;
                end
            end
        end
    end

endmodule
